// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between the CPU datapath (port 0) and the address/branch helper (port 1).
// Optional grant locking is compiled in with `define ALU_ARB_LOCK_EN.
module alu_share_arbiter #(
  parameter int WIDTH    = 24,
  parameter int MAX_LOCK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic [3:0]       i_op0,
  input  logic [3:0]       i_op1,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_b0,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_b1,
  input  logic             i_lock0,
  input  logic             i_lock1,
  output logic             o_gnt0,
  output logic             o_gnt1,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [3:0]       o_alu_ctrl,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_zero,
  output logic             o_resp_valid0,
  output logic             o_resp_valid1,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_err_op
);

  logic             r_last_gnt;
  logic             r_rv0, r_rv1;
  logic [WIDTH-1:0] r_result;
  logic             r_zero, r_err;

  logic w_pick0, w_pick1, w_issue, w_legal;
  logic w_lock_hold, w_lock_own;

`ifdef ALU_ARB_LOCK_EN
  localparam logic [3:0] LMAX = 4'(MAX_LOCK);
  logic       r_lock_vld, r_lock_own;
  logic [3:0] r_lock_cnt;
  logic       w_gnt_lock, w_own_req;

  // The owner keeps the ALU until its budget is spent and the other side is waiting.
  assign w_lock_hold = r_lock_vld && (r_lock_cnt < LMAX);
  assign w_lock_own  = r_lock_own;
  assign w_gnt_lock  = o_gnt1 ? i_lock1 : i_lock0;
  assign w_own_req   = r_lock_own ? i_req1 : i_req0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock_vld <= 1'b0;
      r_lock_own <= 1'b0;
      r_lock_cnt <= '0;
    end else if (w_issue) begin
      if (w_gnt_lock) begin
        r_lock_vld <= 1'b1;
        r_lock_own <= o_gnt1;
        if (r_lock_vld && (r_lock_own == o_gnt1))
          r_lock_cnt <= (r_lock_cnt >= LMAX) ? LMAX : r_lock_cnt + 4'd1;
        else
          r_lock_cnt <= 4'd1;
      end else begin
        r_lock_vld <= 1'b0;
        r_lock_cnt <= '0;
      end
    end else if (r_lock_vld && !w_own_req) begin
      r_lock_vld <= 1'b0;
      r_lock_cnt <= '0;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = i_lock0 ^ i_lock1;
  assign w_lock_hold   = 1'b0;
  assign w_lock_own    = 1'b0;
`endif

  always_comb begin
    w_pick0 = i_req0;
    w_pick1 = i_req1;
    if (i_req0 && i_req1) begin
      if (w_lock_hold) begin
        w_pick0 = !w_lock_own;
        w_pick1 = w_lock_own;
      end else begin
        w_pick0 = r_last_gnt;
        w_pick1 = !r_last_gnt;
      end
    end
  end

  // Grants are suppressed while reset is held so nothing appears to issue.
  assign o_gnt0  = w_pick0 & i_rst_n;
  assign o_gnt1  = w_pick1 & i_rst_n;
  assign w_issue = o_gnt0 | o_gnt1;

  always_comb begin
    o_alu_a    = '0;
    o_alu_b    = '0;
    o_alu_ctrl = 4'b0010;
    if (o_gnt0) begin
      o_alu_a    = i_a0;
      o_alu_b    = i_b0;
      o_alu_ctrl = i_op0;
    end else if (o_gnt1) begin
      o_alu_a    = i_a1;
      o_alu_b    = i_b1;
      o_alu_ctrl = i_op1;
    end
  end

  always_comb begin
    case (o_alu_ctrl)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: w_legal = 1'b1;
      default:                                     w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_gnt <= 1'b1;
      r_rv0      <= 1'b0;
      r_rv1      <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rv0 <= o_gnt0;
      r_rv1 <= o_gnt1;
      if (w_issue) begin
        r_result   <= i_alu_result;
        r_zero     <= i_alu_zero;
        r_err      <= !w_legal;
        r_last_gnt <= o_gnt1;
      end
    end
  end

  assign o_resp_valid0 = r_rv0;
  assign o_resp_valid1 = r_rv1;
  assign o_result      = r_result;
  assign o_zero        = r_zero;
  assign o_err_op      = r_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed literal checks plus randomized traffic against a transaction-level model.
module tb_alu_share_arbiter;
  localparam int W    = 24;
  localparam int MAXL = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1, lock0, lock1;
  logic [3:0]   op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, rv0, rv1, zero, err;
  logic [W-1:0] alu_a, alu_b, alu_res, result;
  logic [3:0]   alu_ctrl;
  logic         alu_zero;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .MAX_LOCK(MAXL)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_op0(op0), .i_op1(op1),
    .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1),
    .i_lock0(lock0), .i_lock1(lock1),
    .o_gnt0(gnt0), .o_gnt1(gnt1),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctrl(alu_ctrl),
    .i_alu_result(alu_res), .i_alu_zero(alu_zero),
    .o_resp_valid0(rv0), .o_resp_valid1(rv1),
    .o_result(result), .o_zero(zero), .o_err_op(err)
  );

  // Reference ALU; illegal codes return a ^ b so captured data is recognizable.
  function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return a ^ b;
    endcase
  endfunction

  assign alu_res  = alu_f(alu_ctrl, alu_a, alu_b);
  assign alu_zero = (alu_res == '0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Transaction-level model state
  int           m_last, m_own, m_cnt, m_g;
  bit           m_lvld, m_rv0, m_rv1, m_zero, m_err;
  logic [W-1:0] m_res;

  task automatic model_reset();
    m_last = 1; m_lvld = 0; m_own = 0; m_cnt = 0;
    m_rv0 = 0; m_rv1 = 0; m_res = '0; m_zero = 0; m_err = 0;
  endtask

  function automatic int model_grant();
    if (!req0 && !req1) return -1;
    if (req0 != req1) return req0 ? 0 : 1;
`ifdef ALU_ARB_LOCK_EN
    if (m_lvld && m_cnt < MAXL) return m_own;
`endif
    return 1 - m_last;
  endfunction

  task automatic model_check();
    logic [W-1:0] ea, eb;
    logic [3:0]   ec;
    m_g = model_grant();
    ea = '0; eb = '0; ec = 4'b0010;
    if (m_g == 0) begin ea = a0; eb = b0; ec = op0; end
    if (m_g == 1) begin ea = a1; eb = b1; ec = op1; end
    chk("gnt0", 32'(gnt0), 32'(m_g == 0));
    chk("gnt1", 32'(gnt1), 32'(m_g == 1));
    chk("alu_a", 32'(alu_a), 32'(ea));
    chk("alu_b", 32'(alu_b), 32'(eb));
    chk("alu_ctrl", 32'(alu_ctrl), 32'(ec));
    chk("resp_valid0", 32'(rv0), 32'(m_rv0));
    chk("resp_valid1", 32'(rv1), 32'(m_rv1));
    chk("result", 32'(result), 32'(m_res));
    chk("zero", 32'(zero), 32'(m_zero));
    chk("err_op", 32'(err), 32'(m_err));
  endtask

  task automatic model_update();
    logic [3:0]   op;
    logic [W-1:0] r;
    bit           lk;
    m_rv0 = (m_g == 0);
    m_rv1 = (m_g == 1);
    if (m_g >= 0) begin
      op = (m_g == 0) ? op0 : op1;
      r = (m_g == 0) ? alu_f(op0, a0, b0) : alu_f(op1, a1, b1);
      m_res = r; m_zero = (r == '0);
      m_err = !(op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7});
      m_last = m_g;
      lk = (m_g == 0) ? lock0 : lock1;
      if (lk) begin
        m_cnt = (m_lvld && m_own == m_g) ? ((m_cnt + 1 > MAXL) ? MAXL : m_cnt + 1) : 1;
        m_lvld = 1; m_own = m_g;
      end else begin
        m_lvld = 0; m_cnt = 0;
      end
    end else if (m_lvld && !((m_own == 0) ? req0 : req1)) begin
      m_lvld = 0; m_cnt = 0;
    end
  endtask

  // Called at negedge+1 with inputs stable; the rising edge follows before the next negedge.
  task automatic step();
    model_check();
    model_update();
    @(negedge clk);
  endtask

  int  exp_seq [10];
  bit  pend0, pend1;

  function automatic logic [3:0] rnd_op();
    logic [3:0] legal [5];
    legal[0] = 4'd0; legal[1] = 4'd1; legal[2] = 4'd2; legal[3] = 4'd6; legal[4] = 4'd7;
    if ($urandom_range(0, 3) == 0) return 4'($urandom);
    return legal[$urandom_range(0, 4)];
  endfunction

  function automatic logic [W-1:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return W'($urandom_range(0, 3));
    return W'($urandom);
  endfunction

  initial begin
    rst_n = 0; req0 = 1; req1 = 0; lock0 = 0; lock1 = 0;
    op0 = 4'd2; op1 = 4'd2; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_gnt0", 32'(gnt0), 32'd0);
    chk("reset_rv0", 32'(rv0), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    @(negedge clk);

    // Single add from port 0 right after reset release
    rst_n = 1; req0 = 1; op0 = 4'b0010; a0 = 24'd5; b0 = 24'd7;
    #1;
    chk("t1_gnt0", 32'(gnt0), 32'd1);
    step();
    req0 = 0;
    #1;
    chk("t1_rv0", 32'(rv0), 32'd1);
    chk("t1_result", 32'(result), 32'd12);
    chk("t1_zero", 32'(zero), 32'd0);
    chk("t1_err", 32'(err), 32'd0);
    step();

    // Illegal op from port 1, then an idle cycle
    req1 = 1; op1 = 4'b1011; a1 = 24'h00F0F0; b1 = 24'h0F0F00;
    #1;
    chk("t3_gnt1", 32'(gnt1), 32'd1);
    step();
    req1 = 0;
    #1;
    chk("t3_rv1", 32'(rv1), 32'd1);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_result", 32'(result), 32'h0FFFF0);
    step();
    #1;
    chk("idle_rv0", 32'(rv0), 32'd0);
    chk("idle_rv1", 32'(rv1), 32'd0);
    chk("idle_result_hold", 32'(result), 32'h0FFFF0);
    chk("idle_ctrl", 32'(alu_ctrl), 32'd2);
    chk("idle_alu_a", 32'(alu_a), 32'd0);
    chk("idle_gnt1", 32'(gnt1), 32'd0);
    step();

    // Both requesting: strict alternation starting at 0
    req0 = 1; req1 = 1; op0 = 4'b0110; a0 = 24'd3; b0 = 24'd3;
    op1 = 4'b0000; a1 = 24'd5; b1 = 24'd6;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_gnt0", 32'(gnt0), 32'(i % 2 == 0));
      if (i % 2 == 1) begin
        chk("t2_rv0", 32'(rv0), 32'd1);
        chk("t2_result", 32'(result), 32'd0);
        chk("t2_zero", 32'(zero), 32'd1);
      end
      step();
    end
    req0 = 0; req1 = 0;
    #1;
    chk("t2_rv1", 32'(rv1), 32'd1);
    chk("t2_result1", 32'(result), 32'd4);
    step();

    // Issue, then reset mid-cycle before the response is consumed
    req0 = 1; op0 = 4'b0010; a0 = 24'd1; b0 = 24'd1;
    #1;
    step();
    rst_n = 0;
    #1;
    chk("rst_rv0", 32'(rv0), 32'd0);
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);

    // Release into a held tie with port 0 asking to lock
    rst_n = 1; req0 = 1; req1 = 1; lock0 = 1; lock1 = 0;
    op1 = 4'b0010; a1 = 24'd2; b1 = 24'd9;
`ifdef ALU_ARB_LOCK_EN
    exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
    exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i == 0) begin
        chk("rel_rv0", 32'(rv0), 32'd0);
        chk("rel_rv1", 32'(rv1), 32'd0);
      end
      chk("lock_seq_gnt1", 32'(gnt1), 32'(exp_seq[i]));
      step();
    end
    req0 = 0; req1 = 0; lock0 = 0;
    #1;
    step();

    // Randomized traffic with withdrawals, illegal ops and random lock requests
    pend0 = 0; pend1 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend0 && $urandom_range(0, 2) != 0) begin
        pend0 = 1; op0 = rnd_op(); a0 = rnd_val(); b0 = rnd_val();
      end else if (pend0 && $urandom_range(0, 9) == 0) pend0 = 0;
      if (!pend1 && $urandom_range(0, 2) != 0) begin
        pend1 = 1; op1 = rnd_op(); a1 = rnd_val(); b1 = rnd_val();
      end else if (pend1 && $urandom_range(0, 9) == 0) pend1 = 0;
      req0 = pend0; req1 = pend1;
      lock0 = ($urandom_range(0, 3) != 0);
      lock1 = ($urandom_range(0, 3) == 0);
      #1;
      step();
      if (m_g == 0) pend0 = 0;
      if (m_g == 1) pend1 = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 24-bit ALU between two requesters: port 0 is the CPU datapath and port 1 is the address/branch helper unit.
- Arbitrates round-robin, one ALU operation per cycle.
- Drives ALU operands and the 4-bit ALU control code, then returns a registered result and zero flag to the granted requester one cycle later.
- Sits between the ALU control decoder outputs and the ALU instance.

Parameters:
- WIDTH, 24, data width of operands and result.
- MAX_LOCK, 4, maximum consecutive locked grants to one requester (used only with ALU_ARB_LOCK_EN); legal range 1..15.

Ports:
- Clock  in  1  single system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req0, Req1  in  1 each  request; held high with stable operands until the matching grant.
- Op0, Op1  in  4 each  ALU control code: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt.
- A0, B0, A1, B1  in  WIDTH each  operands.
- Lock0, Lock1  in  1 each  request to keep the ALU next cycle (effective only with ALU_ARB_LOCK_EN).
- Gnt0, Gnt1  out  1 each  combinational grant; the operation issues this cycle.
- AluA, AluB  out  WIDTH each  operands to the ALU.
- AluCtrl  out  4  control code to the ALU.
- AluResult  in  WIDTH  combinational ALU result.
- AluZero  in  1  combinational ALU zero flag.
- RespValid0, RespValid1  out  1 each  one-cycle pulse; Result/Zero/ErrOp are valid for that requester.
- Result  out  WIDTH  registered result.
- Zero  out  1  registered zero flag.
- ErrOp  out  1  registered; the issued op code was not one of the 5 legal codes.

Behaviour:
- Reset (async, Reset_n=0):
  - RespValid0/1=0, Result=0, Zero=0, ErrOp=0.
  - LastGnt=1, so requester 0 wins the first tie. LockCnt=0, LockOwner cleared.
  - Gnt0/1=0 while reset is asserted.
  - Any operation issued in the cycle reset asserts is dropped; no response is produced after reset releases.
- Arbitration (combinational, from registered LastGnt and the lock state):
  - Only one requesting: it is granted.
  - Both requesting: the requester not in LastGnt is granted.
  - Neither requesting: no grant.
  - Gnt0 and Gnt1 are never high together.
- Datapath mux:
  - The granted requester's A, B and Op drive AluA, AluB and AluCtrl.
  - No grant: AluA=0, AluB=0, AluCtrl=0010 (add), a quiet default.
- Issue edge (rising Clock with a grant):
  - Result<=AluResult, Zero<=AluZero, ErrOp<=(Op not legal).
  - RespValidN<=1 for the granted N only; LastGnt<=N.
- Cycle with no grant: both RespValid go to 0; Result, Zero and ErrOp hold.
- Latency and throughput:
  - Response appears exactly 1 cycle after grant.
  - Throughput is 1 op/cycle.
  - Back-to-back alternating grants are allowed with no bubble.
- An illegal Op still issues. The ALU output is captured as-is and ErrOp=1 for that response.
- Dropping Req before grant withdraws the request. Arbiter state is not affected.
- Arithmetic (overflow, slt signedness) is the ALU's responsibility. The arbiter never modifies data.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- Defined:
  - On an issue edge where the granted requester N has LockN=1, set LockOwner=N and increment LockCnt.
  - While LockOwner is valid, N wins even if the other requester is waiting.
  - Lock is released when any of these hold:
    - LockN=0 on an issue;
    - N does not request in a cycle;
    - LockCnt reaches MAX_LOCK while the other requester is waiting. In that case the other is granted next and LockCnt clears.
  - LockCnt saturates at MAX_LOCK.
- Undefined:
  - Lock0/Lock1 are ignored and no lock registers are built.
  - Arbitration is pure round-robin.

Test Plan:
- Reset release, Req0=1, Op0=0010, A0=5, B0=7 -> Gnt0=1 same cycle; next cycle RespValid0=1, Result=12, Zero=0, ErrOp=0.
- Req0=Req1=1 held for 4 cycles, Op0=0110 with A0=B0=3 -> grants alternate 0,1,0,1; responses to requester 0 show Result=0, Zero=1.
- Req1 only, Op1=1011 -> Gnt1=1; next cycle RespValid1=1, ErrOp=1; the following idle cycle shows RespValid0/1=0 with Result held.
- Issue from Req0, then pull Reset_n low mid-cycle before the next edge -> RespValid0=0 immediately; after release no response appears; the first tie is granted to 0.
- Idle, no requests -> Gnt0/1=0, AluCtrl=0010, AluA=AluB=0.
- ALU_ARB_LOCK_EN with MAX_LOCK=4: Req0=Lock0=1 and Req1=1 held -> 4 consecutive Gnt0, then Gnt1; without the macro -> strict alternation.
